// File: rtl/led_pattern_pkg.sv
// Shared definitions for the 10-step LED pattern: symbol table, phase arithmetic, FSM encoding.
package led_pattern_pkg;

   localparam int unsigned PHASES = 10;

   typedef enum logic [0:0] {
      StAcquire = 1'b0,
      StLocked  = 1'b1
   } state_e;

   // Symbols are {bar, mosca, azul}; out-of-range phases map to the illegal 101 so they never match.
   function automatic logic [2:0] sym_of(input logic [3:0] p);
      logic [2:0] s;
      unique case (p)
         4'd0:    s = 3'b000;
         4'd1:    s = 3'b100;
         4'd2:    s = 3'b110;
         4'd3:    s = 3'b111;
         4'd4:    s = 3'b100;
         4'd5:    s = 3'b011;
         4'd6:    s = 3'b000;
         4'd7:    s = 3'b111;
         4'd8:    s = 3'b010;
         4'd9:    s = 3'b001;
         default: s = 3'b101;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] next_phase(input logic [3:0] p);
      return (p >= 4'(PHASES - 1)) ? 4'd0 : p + 4'd1;
   endfunction

   function automatic logic [PHASES-1:0] rotl1(input logic [PHASES-1:0] v);
      return {v[PHASES-2:0], v[PHASES-1]};
   endfunction

endpackage

// File: rtl/led_sym_match.sv
// Combinational symbol matcher: bit i of match is set when led equals the symbol of phase i.
module led_sym_match
   import led_pattern_pkg::*;
(
   input  logic [2:0]        led_i,
   output logic [PHASES-1:0] match_o
);

   always_comb begin
      match_o = '0;
      for (int i = 0; i < PHASES; i++) begin
         match_o[i] = (led_i == sym_of(4'(i)));
      end
   end

endmodule

// File: rtl/led_pattern_decoder.sv
// Aligns to the repeating 10-step LED pattern, tracks its phase and counts symbol errors.
module led_pattern_decoder
   import led_pattern_pkg::*;
#(
   parameter int unsigned ERR_W      = 8,
   parameter int unsigned MISS_LIMIT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [2:0]       led,
   output logic             locked,
   output logic [3:0]       phase,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);

   state_e              state_q;
   logic [PHASES-1:0]   cand_q;
   logic [3:0]          phase_q;
   logic [2:0]          miss_q;
   logic                err_q;
   logic [ERR_W-1:0]    err_count_q;

   logic [PHASES-1:0]   m;
   logic [PHASES-1:0]   n;
   logic [3:0]          n_cnt;
   logic [3:0]          n_idx;
   logic [3:0]          nxt_phase;
   logic                sym_hit;
   logic [3:0]          miss_inc;
   logic                miss_drop;
   logic                err_hit;

   led_sym_match u_sym_match (
      .led_i   (led),
      .match_o (m)
   );

   always_comb begin
      n     = rotl1(cand_q) & m;
      n_cnt = '0;
      n_idx = '0;
      for (int i = 0; i < PHASES; i++) begin
         if (n[i]) begin
            n_cnt = n_cnt + 4'd1;
            n_idx = 4'(i);
         end
      end
      nxt_phase = next_phase(phase_q);
      sym_hit   = (led == sym_of(nxt_phase));
      miss_inc  = {1'b0, miss_q} + 4'd1;
      miss_drop = (miss_inc >= 4'(MISS_LIMIT));
      err_hit   = valid && ((state_q == StAcquire) ? (m == '0) : !sym_hit);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StAcquire;
         cand_q      <= '1;
         phase_q     <= '0;
         miss_q      <= '0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         err_q <= err_hit;
         if (err_hit && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_q <= err_count_q + 1'b1;
         end
         if (valid) begin
            unique case (state_q)
               StAcquire: begin
                  if (m == '0) begin
                     cand_q <= '1;
                  end else if (n_cnt == 4'd1) begin
                     state_q <= StLocked;
                     phase_q <= n_idx;
                     miss_q  <= '0;
                  end else if (n_cnt > 4'd1) begin
                     cand_q <= n;
                  end else begin
                     cand_q <= m;
                  end
               end
               StLocked: begin
                  // Phase free-wheels on mismatches so a single glitch does not cost alignment.
                  phase_q <= nxt_phase;
                  if (sym_hit) begin
                     miss_q <= '0;
                  end else if (miss_drop) begin
                     state_q <= StAcquire;
                     miss_q  <= '0;
                     cand_q  <= (m == '0) ? '1 : m;
                  end else begin
                     miss_q <= miss_inc[2:0];
                  end
               end
               default: state_q <= StAcquire;
            endcase
         end
      end
   end

   assign locked    = (state_q == StLocked);
   assign phase     = phase_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed bench: each step pushes its expected response to a scoreboard and checks it one edge later.
module tb_led_pattern_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic [2:0] led = 3'b000;
   logic       locked;
   logic [3:0] phase;
   logic       err;
   logic [7:0] err_count;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  exp_ec = '0;

   typedef struct {
      logic       lk;
      logic [3:0] ph;
      logic       ph_chk;
      logic       er;
      logic [7:0] ec;
      string      tag;
   } exp_t;

   exp_t sb[$];

   led_pattern_decoder #(
      .ERR_W      (8),
      .MISS_LIMIT (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .led       (led),
      .locked    (locked),
      .phase     (phase),
      .err       (err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string what, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   // rst=1 asserts reset for this edge; phc=0 leaves phase unchecked.
   task automatic step(input logic rst, input logic v, input logic [2:0] s, input logic lk,
                       input logic [3:0] ph, input logic phc, input logic er, input string tag);
      exp_t e;
      exp_t got;
      @(negedge clk);
      reset = !rst;
      valid = v;
      led   = s;
      if (rst) exp_ec = '0;
      else if (er && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
      e.lk = lk; e.ph = ph; e.ph_chk = phc; e.er = er; e.ec = exp_ec; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk(got.tag, "locked", {7'd0, locked}, {7'd0, got.lk});
      if (got.ph_chk) chk(got.tag, "phase", {4'd0, phase}, {4'd0, got.ph});
      chk(got.tag, "err", {7'd0, err}, {7'd0, got.er});
      chk(got.tag, "err_count", err_count, got.ec);
      reset = 1'b1;
   endtask

   initial begin
      // Reset state
      step(1, 0, 3'b000, 0, 4'd0, 1, 0, "reset");
      step(1, 1, 3'b111, 0, 4'd0, 1, 0, "reset_over_valid");

      // Two-sample acquisition, then a single illegal glitch while locked
      step(0, 1, 3'b000, 0, 4'd0, 0, 0, "acq_000");
      step(0, 1, 3'b100, 1, 4'd1, 1, 0, "acq_100");
      step(0, 1, 3'b110, 1, 4'd2, 1, 0, "trk_p2");
      step(0, 1, 3'b101, 1, 4'd3, 1, 1, "glitch_101");
      step(0, 1, 3'b100, 1, 4'd4, 1, 0, "recover_p4");
      step(0, 1, 3'b011, 1, 4'd5, 1, 0, "trk_p5");
      step(0, 1, 3'b000, 1, 4'd6, 1, 0, "trk_p6");
      step(0, 1, 3'b111, 1, 4'd7, 1, 0, "trk_p7");
      step(0, 1, 3'b010, 1, 4'd8, 1, 0, "trk_p8");
      step(0, 1, 3'b001, 1, 4'd9, 1, 0, "trk_p9");
      step(0, 1, 3'b000, 1, 4'd0, 1, 0, "wrap_p0");
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 3'($urandom_range(7)), 1, 4'd0, 1, 0, "idle_hold");
      end

      // Two consecutive misses drop lock; cand becomes {0,6} from the 000 sample
      step(0, 1, 3'b111, 1, 4'd1, 1, 1, "miss1");
      step(0, 1, 3'b000, 0, 4'd0, 0, 1, "miss2_drop");
      step(0, 1, 3'b100, 1, 4'd1, 1, 0, "reacq");

      // Mid-lock reset discards alignment and the error count
      step(1, 1, 3'b110, 0, 4'd0, 1, 0, "reset_midlock");
      step(0, 1, 3'b011, 1, 4'd5, 1, 0, "single_011");

      // Ambiguous candidate set narrows to one phase
      step(1, 0, 3'b000, 0, 4'd0, 1, 0, "reset2");
      step(0, 1, 3'b111, 0, 4'd0, 0, 0, "multi_111");
      step(0, 1, 3'b100, 1, 4'd4, 1, 0, "narrow_p4");

      // Empty intersection restarts from the current match vector
      step(1, 0, 3'b000, 0, 4'd0, 1, 0, "reset3");
      step(0, 1, 3'b000, 0, 4'd0, 0, 0, "n0_a");
      step(0, 1, 3'b000, 0, 4'd0, 0, 0, "n0_b");
      step(0, 1, 3'b110, 0, 4'd0, 0, 0, "n0_c");
      step(0, 1, 3'b111, 1, 4'd3, 1, 0, "n0_lock");

      // Saturation: illegal symbols in acquire each pulse err
      step(1, 0, 3'b000, 0, 4'd0, 1, 0, "reset4");
      for (int i = 0; i < 256; i++) begin
         step(0, 1, 3'b101, 0, 4'd0, 0, 1, "sat");
      end
      step(0, 0, 3'b101, 0, 4'd0, 0, 0, "sat_hold");

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
